// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data
// memory (slave). Request side is driven by the unit; rdata/ack come back.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Runs one req/ack bus transaction per
// load/store, holds the pipeline with stall until the access completes,
// formats load data for MEM/WB and flags ack timeouts as bus errors.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses skip
// the bus and complete immediately with the misalign flag raised.
module mem_access_unit #(
  parameter int TO_W           = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [1:0]        MemSize_in,
  input  logic              MemSigned_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [31:0]       ALU_in,
  input  logic [31:0]       WD_in,
  input  logic [4:0]        WN_in,
  mem_access_unit_if.master bus,
  output logic              stall,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [31:0]       RD_out,
  output logic [31:0]       ALU_out,
  output logic [4:0]        WN_out,
  output logic              bus_err,
  output logic              misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Last REQ cycle count at which a missing ack turns into a bus error.
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic op;
  logic is_load;
  logic sz_half;
  logic sz_word;
  logic mis_access;
  logic in_idle;
  logic in_req;
  logic in_done;

  // A store wins when both MemRead_in and MemWrite_in are set.
  assign op      = MemRead_in | MemWrite_in;
  assign is_load = MemRead_in & ~MemWrite_in;
  assign sz_half = (MemSize_in == 2'b01);
  assign sz_word = MemSize_in[1];

`ifdef MISALIGN_TRAP_EN
  assign mis_access = op & ((sz_half & ALU_in[0]) | (sz_word & (|ALU_in[1:0])));
`else
  assign mis_access = 1'b0;
`endif

  // State decodes are forced low during reset so every bus/pipeline output
  // is quiet while rst is held, even with an op presented in IDLE.
  assign in_idle = ~rst & (state_q == IDLE);
  assign in_req  = ~rst & (state_q == REQ);
  assign in_done = ~rst & (state_q == DONE);

  // Next-state, timeout counter, error flag and read-data capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mis_access) state_d = DONE;
        else if (op)    state_d = REQ;
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      // NOTE: rdata_q is a single word, so it is reset rather than left
      // unknown; a stale value can never leak into RD_out after reset.
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus request side: address, lane enables and lane-replicated store data.
  always_comb begin
    bus.mem_req  = in_req;
    bus.mem_we   = in_req & MemWrite_in;
    bus.mem_addr = {ALU_in[31:2], 2'b00};
    if (sz_word) begin
      bus.mem_be    = 4'b1111;
      bus.mem_wdata = WD_in;
    end else if (sz_half) begin
      bus.mem_be    = ALU_in[1] ? 4'b1100 : 4'b0011;
      bus.mem_wdata = {2{WD_in[15:0]}};
    end else begin
      bus.mem_be    = 4'b0001 << ALU_in[1:0];
      bus.mem_wdata = {4{WD_in[7:0]}};
    end
  end

  // Load formatting: pick the addressed lane of rdata_q and extend it.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  always_comb begin
    byte_sel = 8'h00;
    case (ALU_in[1:0])
      2'b00: byte_sel = rdata_q[7:0];
      2'b01: byte_sel = rdata_q[15:8];
      2'b10: byte_sel = rdata_q[23:16];
      2'b11: byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = ALU_in[1] ? rdata_q[31:16] : rdata_q[15:0];
    if (sz_word)
      load_fmt = rdata_q;
    else if (sz_half)
      load_fmt = {{16{MemSigned_in & half_sel[15]}}, half_sel};
    else
      load_fmt = {{24{MemSigned_in & byte_sel[7]}}, byte_sel};
  end

  // Pipeline-facing outputs: stall, flags and MEM/WB values.
  always_comb begin
    stall        = (in_idle & op) | in_req;
    bus_err      = in_done & err_q;
    misalign     = in_done & mis_access;
    RegWrite_out = RegWrite_in & ~bus_err & ~misalign;
    MemtoReg_out = MemtoReg_in;
    ALU_out      = ALU_in;
    WN_out       = WN_in;
    RD_out       = (in_done & is_load & ~err_q & ~mis_access) ? load_fmt : 32'h0;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit, directly upstream of the MEM/WB pipeline register.
- Takes EX/MEM control, address and store data; runs a req/ack transaction on the data-memory bus; formats load data (byte/half/word, signed/unsigned).
- Presents RegWrite/MemtoReg/RD/ALU/WN to MEM/WB and raises stall, which drives enReg low on the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers until the access completes.

Parameters:
- TO_W, 8, width of the ack-timeout counter.
- TIMEOUT_CYCLES, 255, number of REQ cycles without ack before a bus error (must be < 2^TO_W).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- MemRead_in  in  1  load instruction in MEM
- MemWrite_in  in  1  store instruction in MEM
- MemSize_in  in  2  00 byte, 01 half, 10 word (11 treated as word)
- MemSigned_in  in  1  1 = sign-extend load, 0 = zero-extend
- RegWrite_in  in  1  EX/MEM RegWrite
- MemtoReg_in  in  1  EX/MEM MemtoReg
- ALU_in  in  32  ALU result / byte address
- WD_in  in  32  store data (rt)
- WN_in  in  5  destination register
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  {ALU_in[31:2],2'b00}
- mem_be  out  4  byte enables, little-endian
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  transaction complete
- stall  out  1  pipeline hold
- RegWrite_out  out  1  to MEM/WB
- MemtoReg_out  out  1  to MEM/WB
- RD_out  out  32  formatted load data to MEM/WB
- ALU_out  out  32  ALU_in passthrough
- WN_out  out  5  WN_in passthrough
- bus_err  out  1  timeout flag, DONE cycle only
- misalign  out  1  misalignment flag (see Optional Feature)

Behaviour:
- FSM states: IDLE, REQ, DONE. op = MemRead_in | MemWrite_in.
- IDLE: if op, stall=1 (combinational) and go to REQ next cycle; otherwise stall=0 and passthrough only.
- REQ: mem_req=1, stall=1; mem_we=MemWrite_in; counter increments each cycle.
  - mem_ack=1: capture mem_rdata into rdata_q, go to DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: set err_q, go to DONE.
- DONE: stall=0, MEM/WB captures this cycle; next state IDLE; counter and err_q cleared.
- Minimum cost is 2 stall cycles (ack in the first REQ cycle); a non-memory instruction costs 0.
- MemRead_in and MemWrite_in both 1: treated as a store.
- mem_be: byte 4'b0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
- mem_wdata: byte {4{WD[7:0]}}; half {2{WD[15:0]}}; word WD.
- RD_out: selected lane of rdata_q, extended per MemSigned_in.
  - Value is 0 when not in DONE, on stores, or when bus_err=1.
- RegWrite_out = RegWrite_in & ~bus_err & ~misalign.
- ALU_out, WN_out, MemtoReg_out: combinational passthrough.
- mem_ack outside REQ is ignored.
- Inputs are held stable by the stall; the block does not re-sample them.
- rst (any state, including mid-REQ): state=IDLE, counter=0, rdata_q=0, err_q=0.
  - While rst=1: stall, mem_req, mem_we, bus_err, misalign and RD_out are all 0.
  - A late ack after reset is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: half access with addr[0]=1, or word access with addr[1:0]!=0, goes IDLE->DONE directly.
  - No mem_req; misalign=1 in DONE; RegWrite_out=0; RD_out=0; 1 stall cycle.
- Undefined: misalign tied 0; low address bits below access size are ignored (half uses addr[1], word ignores addr[1:0]).

Test Plan:
- lw, ALU_in=0x100, ack on 1st REQ cycle, rdata=0x89ABCDEF -> stall high 2 cycles; DONE: RD_out=0x89ABCDEF, mem_be=1111, mem_addr=0x100.
- lb addr=0x103 signed, rdata=0x80FF7F01 -> RD_out=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x102 -> 0x000080FF.
- sb addr=0x201, WD_in=0x12345678, ack after 3 cycles -> mem_we=1, mem_be=0010, mem_wdata=0x78787878, stall 4 cycles, RD_out=0.
- lw with no ack, TIMEOUT_CYCLES=4 -> DONE after 4 REQ cycles, bus_err=1 for one cycle, RegWrite_out=0, RD_out=0.
- rst pulsed during REQ, then ack 1 cycle later -> mem_req=0 immediately, state IDLE, ack ignored, stall=0 while rst=1.
- MISALIGN_TRAP_EN, lw addr=0x102 -> no mem_req, misalign=1, 1 stall cycle; undefined -> mem_addr=0x100, normal load.
